// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: issue/result bundle between the ID/EX register, alu_exec_unit and the
// writeback mux.
//   flush                        abort any operation in flight
//   in_valid / in_ready          issue handshake
//   alu_op, funct3, funct7       operation select
//   op_a, op_b                   operands
//   out_valid / out_ready        result handshake
//   result, zero, illegal        registered result and flags
//   busy                         multi-cycle operation iterating
// Modports: master drives the operation and consumes the result; slave is the execute unit.

interface alu_exec_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;
  logic            busy;

  modport master (
    output flush, in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal, busy
  );

  modport slave (
    input  flush, in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal, busy
  );

endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALUOp/funct3/funct7 decode merged with a registered execute stage.
// Base operations complete one cycle after accept; the result is held until out_ready.
// Optional macro ALU_EXEC_MDU_EN adds RV32M-style mul/div (funct7 = 0000001) executed
// iteratively over XLEN cycles; without it that encoding decodes as illegal and busy is 0.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      alu_exec_unit_if.slave (flush, issue handshake + operands, result handshake,
//            result/zero/illegal, busy)

module alu_exec_unit #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned SHW = $clog2(XLEN)
) (
  input logic           clk,
  input logic           rst_n,
  alu_exec_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic            in_ready;
  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] sra_res;
  logic            dec_illegal;
  logic            dec_mdu;
  logic            mdu_last;
  logic [XLEN-1:0] mdu_res;

  assign in_ready = (state_q == StIdle) | ((state_q == StDone) & bus.out_ready);
  // flush wins over a simultaneous offer
  assign accept   = bus.in_valid & in_ready & ~bus.flush;
  assign shamt    = bus.op_b[SHW-1:0];
  // Kept as its own signal so the arithmetic shift is not turned logical by a mixed-sign
  // expression around it.
  assign sra_res  = $signed(bus.op_a) >>> shamt;

  // --------------------------------------------------------------------------
  // Decode and single-cycle datapath (illegal ops leave alu_res at zero)
  // --------------------------------------------------------------------------
  always_comb begin
    alu_res     = '0;
    dec_illegal = 1'b0;
    dec_mdu     = 1'b0;
    unique case (bus.alu_op)
      2'b00: alu_res = bus.op_a + bus.op_b;
      2'b01: alu_res = bus.op_a - bus.op_b;
      2'b11: alu_res = bus.op_b;
      default: begin
        if (bus.funct7 == 7'b0000000 || bus.funct7 == 7'b0100000) begin
          unique case (bus.funct3)
            3'b000: begin
              if (bus.funct7[5]) alu_res = bus.op_a - bus.op_b;
              else               alu_res = bus.op_a + bus.op_b;
            end
            3'b001: alu_res = bus.op_a << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
            3'b100: alu_res = bus.op_a ^ bus.op_b;
            3'b101: begin
              if (bus.funct7[5]) alu_res = sra_res;
              else               alu_res = bus.op_a >> shamt;
            end
            3'b110: alu_res = bus.op_a | bus.op_b;
            3'b111: alu_res = bus.op_a & bus.op_b;
          endcase
        end
`ifdef ALU_EXEC_MDU_EN
        else if (bus.funct7 == 7'b0000001) begin
          dec_mdu = 1'b1;
        end
`endif
        else begin
          dec_illegal = 1'b1;
        end
      end
    endcase
  end

`ifdef ALU_EXEC_MDU_EN
  // --------------------------------------------------------------------------
  // Iterative multiply/divide on operand magnitudes, sign fixed up at the end.
  // Multiply: {acc, lo} is the shifting product, lo starts as the multiplier.
  // Divide:   acc is the partial remainder, lo shifts the dividend out and the
  //           quotient in.
  // --------------------------------------------------------------------------
  logic                mdu_load;
  logic [XLEN-1:0]     acc_q, lo_q, dvs_q;
  logic [SHW-1:0]      cnt_q;
  logic [2:0]          mf3_q;
  logic                neg_q;
  logic                div0_q;
  logic                sa, sb;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       sum, shifted, trial;
  logic [XLEN-1:0]     acc_n, lo_n;
  logic [2*XLEN-1:0]   prod, prod_s;

  assign sa    = bus.op_a[XLEN-1] & (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
  assign sb    = bus.op_b[XLEN-1] & (bus.funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
  assign a_mag = sa ? -bus.op_a : bus.op_a;
  assign b_mag = sb ? -bus.op_b : bus.op_b;

  always_comb begin
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    shifted = {acc_q, lo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (mf3_q[2]) begin
      // Restoring step: keep the difference only when it did not go negative.
      if (!trial[XLEN]) begin
        acc_n = trial[XLEN-1:0];
        lo_n  = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        acc_n = shifted[XLEN-1:0];
        lo_n  = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_n = sum[XLEN:1];
      lo_n  = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign prod     = {acc_n, lo_n};
  assign prod_s   = neg_q ? -prod : prod;
  assign mdu_last = (cnt_q == SHW'(XLEN - 1));

  always_comb begin
    mdu_res = '0;
    unique case (mf3_q)
      3'b000:                 mdu_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: mdu_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (div0_q)     mdu_res = '1;
        else if (neg_q) mdu_res = -lo_n;
        else            mdu_res = lo_n;
      end
      default: mdu_res = neg_q ? -acc_n : acc_n;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      lo_q   <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      mf3_q  <= '0;
      neg_q  <= 1'b0;
      div0_q <= 1'b0;
    end else if (mdu_load) begin
      acc_q  <= '0;
      lo_q   <= bus.funct3[2] ? a_mag : b_mag;
      dvs_q  <= bus.funct3[2] ? b_mag : a_mag;
      cnt_q  <= '0;
      mf3_q  <= bus.funct3;
      // Remainder takes the dividend's sign; product/quotient take the XOR.
      neg_q  <= (bus.funct3[2] & bus.funct3[1]) ? sa : (sa ^ sb);
      // Only the quotient needs an override; the remainder falls out as op_a.
      div0_q <= bus.funct3[2] & ~bus.funct3[1] & (bus.op_b == '0);
    end else if (state_q == StExec) begin
      acc_q  <= acc_n;
      lo_q   <= lo_n;
      cnt_q  <= cnt_q + SHW'(1);
    end
  end

  assign bus.busy = (state_q == StExec);
`else
  assign mdu_last = 1'b0;
  assign mdu_res  = '0;
  assign bus.busy = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_EXEC_MDU_EN
    mdu_load  = 1'b0;
`endif
    if (bus.flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            if (dec_mdu) begin
              state_d  = StExec;
`ifdef ALU_EXEC_MDU_EN
              mdu_load = 1'b1;
`endif
            end else begin
              state_d   = StDone;
              result_d  = alu_res;
              zero_d    = (alu_res == '0);
              illegal_d = dec_illegal;
            end
          end else if ((state_q == StDone) && bus.out_ready) begin
            state_d = StIdle;
          end
        end
        StExec: begin
          if (mdu_last) begin
            state_d   = StDone;
            result_d  = mdu_res;
            zero_d    = (mdu_res == '0);
            illegal_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed cases plus a randomized run scored against a
// behavioural model of the operation set and the handshake timing.

module tb_alu_exec_unit;

  localparam int unsigned XLEN = 32;
`ifdef ALU_EXEC_MDU_EN
  localparam int MDU_LAT = XLEN + 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {illegal, result}
  function automatic logic [32:0] ref_op(input logic [1:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, sh;
    logic [63:0] p;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    sh = longint'(b % 32);
    p  = '0;
    case (op)
      2'd0: return {1'b0, a + b};
      2'd1: return {1'b0, a - b};
      2'd3: return {1'b0, b};
      default: ;
    endcase
    if (f7 == 7'h00 || f7 == 7'h20) begin
      case (f3)
        3'd0: return {1'b0, (f7 == 7'h20) ? a - b : a + b};
        3'd1: return {1'b0, a << sh};
        3'd2: return {1'b0, (sa < sb) ? 32'd1 : 32'd0};
        3'd3: return {1'b0, (ua < ub) ? 32'd1 : 32'd0};
        3'd4: return {1'b0, a ^ b};
        3'd5: begin
          p = sa >>> sh;
          return {1'b0, (f7 == 7'h20) ? p[31:0] : a >> sh};
        end
        3'd6: return {1'b0, a | b};
        default: return {1'b0, a & b};
      endcase
    end
`ifdef ALU_EXEC_MDU_EN
    if (f7 == 7'h01) begin
      case (f3)
        3'd0: begin p = sa * sb; return {1'b0, p[31:0]}; end
        3'd1: begin p = sa * sb; return {1'b0, p[63:32]}; end
        3'd2: begin p = sa * longint'(ub); return {1'b0, p[63:32]}; end
        3'd3: begin p = ua * ub; return {1'b0, p[63:32]}; end
        3'd4: begin
          if (b == 0) return {1'b0, 32'hFFFF_FFFF};
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, a};
          p = sa / sb;
          return {1'b0, p[31:0]};
        end
        3'd5: return {1'b0, (b == 0) ? 32'hFFFF_FFFF : a / b};
        3'd6: begin
          if (b == 0) return {1'b0, a};
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 33'd0;
          p = sa % sb;
          return {1'b0, p[31:0]};
        end
        default: return {1'b0, (b == 0) ? a : a % b};
      endcase
    end
`endif
    return {1'b1, 32'h0};
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [6:0] f7);
`ifdef ALU_EXEC_MDU_EN
    if (op == 2'd2 && f7 == 7'h01) return MDU_LAT;
`endif
    return 1;
  endfunction

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    bus.alu_op = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.op_a   = a;
    bus.op_b   = b;
  endtask

  // Issue one op from idle, measure latency, check result, then drain it.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] exp;
    int lat_exp;
    int lat;
    exp     = ref_op(op, f3, f7, a, b);
    lat_exp = ref_lat(op, f7);
    drive(op, f3, f7, a, b);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    lat = 0;
    while (lat < XLEN + 10) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat++;
      if (lat == 1) check({tag, "/busy"}, bus.busy, lat_exp > 1);
      if (bus.out_valid) break;
    end
    check({tag, "/lat"}, lat, lat_exp);
    check({tag, "/result"}, bus.result, exp[31:0]);
    check({tag, "/illegal"}, bus.illegal, exp[32]);
    check({tag, "/zero"}, bus.zero, exp[31:0] == 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          rdy;
  } exp_t;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    logic [31:0] bb_exp[4];
    logic [32:0] e;
    exp_t q[$];
    logic rose;

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(2'd0, 3'd0, 7'd0, 32'd0, 32'd0);

    // Asynchronous reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst/out_valid", bus.out_valid, 1'b0);
    check("rst/result", bus.result, 32'h0);
    check("rst/zero", bus.zero, 1'b0);
    check("rst/illegal", bus.illegal, 1'b0);
    check("rst/busy", bus.busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rst/in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed operations
    run_op("sub_f7", 2'd2, 3'd0, 7'h20, 32'd5, 32'd7);
    run_op("sra", 2'd2, 3'd5, 7'h20, 32'h8000_0000, 32'h24);
    run_op("srl", 2'd2, 3'd5, 7'h00, 32'h8000_0000, 32'h24);
    run_op("sll", 2'd2, 3'd1, 7'h00, 32'h1, 32'h21);
    run_op("slt", 2'd2, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'h1);
    run_op("sltu", 2'd2, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'h1);
    run_op("add_wrap", 2'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'h1);
    run_op("pass_b", 2'd3, 3'd7, 7'h7F, 32'h1234, 32'hCAFE_F00D);
    run_op("ill_f7_10", 2'd2, 3'd0, 7'h10, 32'd5, 32'd7);
    run_op("f7_01", 2'd2, 3'd0, 7'h01, 32'd5, 32'd7);
`ifdef ALU_EXEC_MDU_EN
    run_op("div0", 2'd2, 3'd4, 7'h01, 32'd7, 32'd0);
    run_op("rem_ovf", 2'd2, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'd2, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mulh", 2'd2, 3'd1, 7'h01, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhsu", 2'd2, 3'd2, 7'h01, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    run_op("rem_neg", 2'd2, 3'd6, 7'h01, 32'hFFFF_FF9C, 32'd7);
    run_op("remu0", 2'd2, 3'd7, 7'h01, 32'hDEAD_BEEF, 32'd0);
`endif

    // Back-to-back issue at full throughput, then a 3-cycle stall
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'd2, 3'($urandom_range(0, 7)), 7'h00, $urandom, $urandom);
      e = ref_op(bus.alu_op, bus.funct3, bus.funct7, bus.op_a, bus.op_b);
      bb_exp[i] = e[31:0];
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("b2b/out_valid", bus.out_valid, 1'b1);
      check("b2b/result", bus.result, bb_exp[i]);
    end
    bus.out_ready = 1'b0;
    drive(2'd3, 3'd0, 7'd0, 32'd0, ~bb_exp[3]);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall/in_ready", bus.in_ready, 1'b0);
      check("stall/out_valid", bus.out_valid, 1'b1);
      check("stall/result", bus.result, bb_exp[3]);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drain/out_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;

    // flush drops a simultaneous offer
    drive(2'd0, 3'd0, 7'd0, 32'd1, 32'd2);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_drop/out_valid", bus.out_valid, 1'b0);

    // flush discards a held result
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("flush_held/pre", bus.out_valid, 1'b1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_held/out_valid", bus.out_valid, 1'b0);
    check("flush_held/in_ready", bus.in_ready, 1'b1);

`ifdef ALU_EXEC_MDU_EN
    // flush on the 10th EXEC cycle of a divu, then a new add right behind it
    drive(2'd2, 3'd5, 7'h01, 32'd1000, 32'd3);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mdu_flush/busy", bus.busy, 1'b1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("mdu_flush/idle_busy", bus.busy, 1'b0);
    check("mdu_flush/in_ready", bus.in_ready, 1'b1);
    drive(2'd0, 3'd0, 7'd0, 32'd40, 32'd2);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("mdu_flush/add_valid", bus.out_valid, 1'b1);
    check("mdu_flush/add_result", bus.result, 32'd42);
    bus.out_ready = 1'b1;
    rose = 1'b0;
    for (int i = 0; i < XLEN + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) rose = 1'b1;
    end
    bus.out_ready = 1'b0;
    check("mdu_flush/no_stale_result", rose, 1'b0);

    // reset in the middle of EXEC
    drive(2'd2, 3'd4, 7'h01, 32'd99, 32'd5);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_exec/busy", bus.busy, 1'b0);
`else
    // reset while a non-zero result is held
    drive(2'd0, 3'd0, 7'd0, 32'd40, 32'd2);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
`endif
    check("rst_mid/out_valid", bus.out_valid, 1'b0);
    check("rst_mid/result", bus.result, 32'h0);
    check("rst_mid/flags", {bus.zero, bus.illegal}, 2'b00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against a queue-based model of results and timing
    for (int c = 0; c < 400; c++) begin
      logic [6:0] f7;
      logic [31:0] a, b;
      logic ev, bsy, er;
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), f7, a, b);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ev  = (q.size() > 0) && (c >= q[0].rdy);
      bsy = (q.size() > 0) && (c < q[0].rdy);
      er  = (q.size() == 0) || (ev && bus.out_ready);
      check("rnd/out_valid", bus.out_valid, ev);
      check("rnd/in_ready", bus.in_ready, er);
      check("rnd/busy", bus.busy, bsy);
      if (ev && bus.out_ready) begin
        check("rnd/result", bus.result, q[0].res);
        check("rnd/illegal", bus.illegal, q[0].ill);
        check("rnd/zero", bus.zero, q[0].res == 0);
        void'(q.pop_front());
      end
      if (bus.in_valid && er) begin
        e = ref_op(bus.alu_op, bus.funct3, bus.funct7, bus.op_a, bus.op_b);
        q.push_back('{res: e[31:0], ill: e[32], rdy: c + ref_lat(bus.alu_op, bus.funct7)});
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
